// File: rtl/chacha_ks_sched_if.sv
// Job request and keystream delivery channels of the ChaCha keystream scheduler.
// The master side is the job requester / keystream consumer; the slave side is the scheduler.
interface chacha_ks_sched_if #(
    parameter int CNT_W = 16
);
    logic             job_valid;
    logic             job_ready;
    logic [255:0]     job_key;
    logic [63:0]      job_iv;
    logic [63:0]      job_ctr;
    logic [CNT_W-1:0] job_nblocks;
    logic             ks_valid;
    logic             ks_ready;
    logic [511:0]     ks_data;
    logic [63:0]      ks_ctr;
    logic             ks_last;

    modport master (
        output job_valid, job_key, job_iv, job_ctr, job_nblocks, ks_ready,
        input  job_ready, ks_valid, ks_data, ks_ctr, ks_last
    );

    modport slave (
        input  job_valid, job_key, job_iv, job_ctr, job_nblocks, ks_ready,
        output job_ready, ks_valid, ks_data, ks_ctr, ks_last
    );
endinterface

// File: rtl/chacha_ks_sched.sv
// Sequences chacha_core through a multi-block job (init, then next per block), buffering one
// 512-bit result at a time, with acceptance-time counter wrap check and a result watchdog.
module chacha_ks_sched #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    chacha_ks_sched_if.slave    bus,
    output logic                busy_o,
    output logic                err_wrap_o,
    output logic                err_timeout_o,
    output logic                core_init_o,
    output logic                core_next_o,
    output logic [255:0]        core_key_o,
    output logic [63:0]         core_iv_o,
    output logic [63:0]         core_ctr_o,
    input  logic                core_ready_i,
    input  logic [511:0]        core_data_out_i,
    input  logic                core_data_out_valid_i
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             jobReady_q, busy_q;
    logic [255:0]     key_q, key_d;
    logic [63:0]      iv_q, iv_d;
    logic [63:0]      jobCtr_q, jobCtr_d;
    logic [63:0]      blkCtr_q, blkCtr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WD_W-1:0]  wd_q, wd_d, wdInc;
    logic             first_q, first_d;
    logic [511:0]     buf_q, buf_d;
    logic [63:0]      ksCtr_q, ksCtr_d;
    logic             ksValid_q, ksValid_d;
    logic             ksLast_q, ksLast_d;
    logic             init_q, init_d;
    logic             next_q, next_d;
    logic             errWrap_q, errWrap_d;
    logic             errTo_q, errTo_d;
    logic [64:0]      endCtr;

    assign wdInc = wd_q + WD_W'(1);

    always_comb begin
        endCtr    = {1'b0, bus.job_ctr} + 65'(bus.job_nblocks) - 65'd1;
        state_d   = state_q;
        key_d     = key_q;
        iv_d      = iv_q;
        jobCtr_d  = jobCtr_q;
        blkCtr_d  = blkCtr_q;
        rem_d     = rem_q;
        wd_d      = wd_q;
        first_d   = first_q;
        buf_d     = buf_q;
        ksCtr_d   = ksCtr_q;
        ksValid_d = ksValid_q;
        ksLast_d  = ksLast_q;
        init_d    = 1'b0;
        next_d    = 1'b0;
        errWrap_d = 1'b0;
        errTo_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.job_valid && jobReady_q) begin
                    key_d    = bus.job_key;
                    iv_d     = bus.job_iv;
                    jobCtr_d = bus.job_ctr;
                    blkCtr_d = bus.job_ctr;
                    rem_d    = bus.job_nblocks;
                    first_d  = 1'b1;
                    // Empty jobs and jobs whose last counter would overflow are consumed silently
                    // (wrap raises a flag); the command fires at once when the core is already idle.
                    if (bus.job_nblocks == '0) begin
                        state_d = S_IDLE;
                    end else if (endCtr[64]) begin
                        errWrap_d = 1'b1;
                    end else if (core_ready_i) begin
                        init_d  = 1'b1;
                        first_d = 1'b0;
                        wd_d    = '0;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (core_ready_i) begin
                    init_d  = first_q;
                    next_d  = !first_q;
                    first_d = 1'b0;
                    wd_d    = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // The valid level seen in the first WAIT cycle belongs to the previous block.
                if (wd_q != '0 && core_ready_i && core_data_out_valid_i) begin
                    buf_d     = core_data_out_i;
                    ksCtr_d   = blkCtr_q;
                    ksLast_d  = (rem_q == CNT_W'(1));
                    ksValid_d = 1'b1;
                    state_d   = S_HOLD;
                end else if (wdInc == WD_W'(TIMEOUT)) begin
                    errTo_d = 1'b1;
                    rem_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wdInc;
                end
            end
            S_HOLD: begin
                if (bus.ks_ready) begin
                    ksValid_d = 1'b0;
                    ksLast_d  = 1'b0;
                    blkCtr_d  = blkCtr_q + 64'd1;
                    rem_d     = rem_q - CNT_W'(1);
                    if (ksLast_q) begin
                        state_d = S_IDLE;
                    end else if (core_ready_i) begin
                        next_d  = 1'b1;
                        wd_d    = '0;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            jobReady_q <= 1'b1;
            busy_q     <= 1'b0;
            key_q      <= '0;
            iv_q       <= '0;
            jobCtr_q   <= '0;
            blkCtr_q   <= '0;
            rem_q      <= '0;
            wd_q       <= '0;
            first_q    <= 1'b0;
            buf_q      <= '0;
            ksCtr_q    <= '0;
            ksValid_q  <= 1'b0;
            ksLast_q   <= 1'b0;
            init_q     <= 1'b0;
            next_q     <= 1'b0;
            errWrap_q  <= 1'b0;
            errTo_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            jobReady_q <= (state_d == S_IDLE);
            busy_q     <= (state_d != S_IDLE);
            key_q      <= key_d;
            iv_q       <= iv_d;
            jobCtr_q   <= jobCtr_d;
            blkCtr_q   <= blkCtr_d;
            rem_q      <= rem_d;
            wd_q       <= wd_d;
            first_q    <= first_d;
            buf_q      <= buf_d;
            ksCtr_q    <= ksCtr_d;
            ksValid_q  <= ksValid_d;
            ksLast_q   <= ksLast_d;
            init_q     <= init_d;
            next_q     <= next_d;
            errWrap_q  <= errWrap_d;
            errTo_q    <= errTo_d;
        end
    end

    assign bus.job_ready = jobReady_q;
    assign bus.ks_valid  = ksValid_q;
    assign bus.ks_data   = buf_q;
    assign bus.ks_ctr    = ksCtr_q;
    assign bus.ks_last   = ksLast_q;
    assign busy_o        = busy_q;
    assign err_wrap_o    = errWrap_q;
    assign err_timeout_o = errTo_q;
    assign core_init_o   = init_q;
    assign core_next_o   = next_q;
    assign core_key_o    = key_q;
    assign core_iv_o     = iv_q;
    assign core_ctr_o    = jobCtr_q;
endmodule

// File: doc/chacha_ks_sched.md
# chacha_ks_sched

Keystream scheduler sitting in front of `chacha_core`. It accepts a job (key, IV, starting block counter, block count) over a valid/ready handshake and sequences the core with one `init` for the first block and a `next` for each later block. Each 512-bit block is captured into a single output buffer and delivered downstream with backpressure. It also checks for counter wrap-around and raises a watchdog error if the core stops responding.

## Interface
- `CNT_W`, 16, width of the job block count.
- `TIMEOUT`, 64, maximum number of cycles the scheduler waits for a core result before aborting.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `job_valid`  in  1  job request.
- `job_ready`  out  1  job accepted when `job_valid & job_ready`.
- `job_key`  in  256  key.
- `job_iv`  in  64  IV.
- `job_ctr`  in  64  counter of the first block.
- `job_nblocks`  in  CNT_W  number of blocks to produce.
- `ks_valid`  out  1  keystream block available.
- `ks_ready`  in  1  downstream accepts the block.
- `ks_data`  out  512  keystream block.
- `ks_ctr`  out  64  counter value of `ks_data`.
- `ks_last`  out  1  final block of the job.
- `busy`  out  1  a job is in progress.
- `err_wrap`  out  1  one-cycle pulse: job rejected because of counter wrap.
- `err_timeout`  out  1  one-cycle pulse: job aborted by the watchdog.
- `core_init`, `core_next`  out  1  one-cycle command pulses to the core.
- `core_key`, `core_iv`, `core_ctr`  out  256/64/64  job parameters held stable for the whole job.
- `core_ready`  in  1  core idle.
- `core_data_out`  in  512  core result.
- `core_data_out_valid`  in  1  core result valid (level).

## Operation
- States:
  - IDLE: `job_ready=1`. Only this state asserts `job_ready`.
  - ISSUE: waits for `core_ready=1`, then pulses `core_init` (first block) or `core_next` (later blocks) for exactly one cycle.
  - WAIT: waits for the core result.
  - HOLD: buffer full; waits for downstream to take the block.
- On job acceptance, the key, IV, counter and block count are registered into the job registers; the `core_*` parameter outputs are driven from these registers.
- Acceptance with `job_nblocks=0`:
  - job is consumed, no core command is issued, no error is raised;
  - state stays IDLE.
- Wrap check: if `job_ctr + job_nblocks - 1 > 2^64-1`:
  - job is consumed, `err_wrap` pulses in the cycle after acceptance;
  - no blocks are produced and state stays IDLE.
- WAIT behaviour:
  - `core_data_out_valid` is ignored in the first WAIT cycle, because the level may be stale from the previous block.
  - From the second WAIT cycle on, `core_ready & core_data_out_valid` captures `core_data_out` into the buffer, sets `ks_ctr` to the current block counter, and sets `ks_last=1` when remaining blocks = 1. State → HOLD.
- HOLD behaviour:
  - On `ks_valid & ks_ready`: the block counter increments, remaining blocks decrement, and the buffer empties.
  - State → IDLE if `ks_last`, else → ISSUE, which then pulses `core_next`.
- Ordering guarantees:
  - At most one core command is outstanding at a time.
  - A new command is issued only after the buffer has emptied, so the core can never overwrite an unconsumed result.
- Watchdog:
  - A counter runs in WAIT and clears on every ISSUE.
  - If it reaches `TIMEOUT` without a capture: `err_timeout` pulses once, the remaining blocks are dropped, and state → IDLE.
- `ks_data` and `ks_ctr` hold stable while `ks_valid=1 & ks_ready=0`.
- `job_valid` presented in any state other than IDLE is ignored; the requester must hold it until accepted.
- `busy=1` in every state except IDLE.

## Timing
- Reset values:
  - state IDLE;
  - `job_ready=1`;
  - `ks_valid=0`, `ks_last=0`, `busy=0`;
  - `err_wrap=0`, `err_timeout=0`;
  - `core_init=0`, `core_next=0`;
  - `ks_data`, `ks_ctr`, `core_key`, `core_iv`, `core_ctr` = 0.
- Reset asserted in any state, including mid-WAIT or HOLD:
  - all outputs take their reset values in the next cycle;
  - the buffered block is discarded;
  - a core result arriving afterwards is ignored.
- All outputs are registered.
- Job accepted at edge T:
  - `core_init` is high in cycle T+1 if `core_ready=1`;
  - a capture at edge C gives `ks_valid=1` from cycle C+1.
- Handshake at edge H on a non-last block: `core_next` is high in cycle H+1 (given `core_ready=1`).
- Last-block handshake at edge H: `job_ready=1` from cycle H+1.
- A `core_init`/`core_next` pulse is never longer than one cycle, and the two are never high together.
- Counter arithmetic is 64-bit. No wrap can occur inside a job that passed the acceptance check.

## Test plan
- Single block: key=0123456789abcdef repeated four times, iv=deadbeefcafebabe, ctr=0, nblocks=1, `ks_ready=1` → exactly one `core_init` and no `core_next`; `ks_valid` with `ks_ctr=0`, `ks_last=1`, `ks_data` equal to the core's output; `job_ready` returns high the cycle after the handshake.
- Three blocks with `ks_ready` held low for 5 cycles on each block → one `core_init` and two `core_next`; `ks_ctr` = 0, 1, 2; `ks_data` stable during each stall; `ks_last` set only on the third block; no command issued while `ks_valid=1`.
- nblocks=0 → no core commands, no `ks_valid`, no error; next job accepted normally.
- ctr=FFFFFFFFFFFFFFFE, nblocks=3 → `err_wrap` pulses once, no core commands; ctr=FFFFFFFFFFFFFFFE, nblocks=2 → two blocks with `ks_ctr` = …FE, …FF.
- Core stub that never asserts valid, `TIMEOUT=64` → `err_timeout` pulses 64 cycles into WAIT, state returns to IDLE, `ks_valid` never rises.
- `rst` pulsed during WAIT of a 4-block job, then the core result arrives → no `ks_valid`, all outputs at reset values, `job_ready=1`.
